// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Address layout (word address): [TAG_LSB +: TAG_W] tag, [IDX_LSB +: IDX_W] index, [OFS_LSB +: OFS_W] word.
package dcache_pkg;

    localparam int unsigned ADDR_W  = 30;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned OFS_W   = 2;
    localparam int unsigned TAG_W   = ADDR_W - IDX_W - OFS_W;
    localparam int unsigned WORDS   = 1 << OFS_W;
    localparam int unsigned LINE_W  = WORDS * WORD_W;
    localparam int unsigned MADDR_W = ADDR_W - OFS_W;
    localparam int unsigned NLINES  = 1 << IDX_W;

    localparam int unsigned OFS_LSB = 0;
    localparam int unsigned IDX_LSB = OFS_LSB + OFS_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

    // Word 0 of a line occupies bits [WORD_W-1:0].
    typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_e;

endpackage

// File: rtl/dcache_wb_dm_if.sv
// Core-side (word) and memory-side (line) ports of the data cache.
// The cache is the slave of dcache_proc_if and the master of dcache_mem_if.
interface dcache_proc_if;
    import dcache_pkg::*;

    logic              proc_ren;
    logic              proc_wen;
    logic [ADDR_W-1:0] proc_addr;
    logic [WORD_W-1:0] proc_wdata;
    logic              proc_stall;
    logic [WORD_W-1:0] proc_rdata;

    modport master (output proc_ren, proc_wen, proc_addr, proc_wdata,
                    input  proc_stall, proc_rdata);
    modport slave  (input  proc_ren, proc_wen, proc_addr, proc_wdata,
                    output proc_stall, proc_rdata);
endinterface

interface dcache_mem_if;
    import dcache_pkg::*;

    logic               mem_read;
    logic               mem_write;
    logic [MADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic               mem_ready;
    logic [LINE_W-1:0]  mem_rdata;

    modport master (output mem_read, mem_write, mem_addr, mem_wdata,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_read, mem_write, mem_addr, mem_wdata,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage with one combinational read port,
// a word-write port (sets dirty) and a line-fill port (sets valid, clears dirty).
module dcache_array
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx_i,
    output logic [TAG_W-1:0] tag_o,
    output logic             valid_o,
    output logic             dirty_o,
    output line_t            line_o,
    input  logic             word_we_i,
    input  logic [OFS_W-1:0] word_ofs_i,
    input  logic [WORD_W-1:0] word_data_i,
    input  logic             line_we_i,
    input  logic [TAG_W-1:0] line_tag_i,
    input  line_t            line_data_i
);

    logic [NLINES-1:0] valid_q;
    logic [NLINES-1:0] dirty_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    line_t             data_q [NLINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tags and data are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (line_we_i) begin
            data_q[idx_i] <= line_data_i;
            tag_q[idx_i]  <= line_tag_i;
        end else if (word_we_i) begin
            data_q[idx_i][word_ofs_i] <= word_data_i;
        end
    end

    assign tag_o   = tag_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache: zero-latency hits,
// dirty victim write-back followed by a line fill on a miss.
module dcache_wb_dm
    import dcache_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    dcache_proc_if.slave  proc,
    dcache_mem_if.master  mem
);

    state_e state_q, state_d;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [OFS_W-1:0] ofs;
    logic [TAG_W-1:0] arr_tag;
    logic             arr_valid;
    logic             arr_dirty;
    line_t            arr_line;
    logic             hit;
    logic             req;
    logic             word_we;
    logic             line_we;

    assign idx = proc.proc_addr[IDX_LSB +: IDX_W];
    assign tag = proc.proc_addr[TAG_LSB +: TAG_W];
    assign ofs = proc.proc_addr[OFS_LSB +: OFS_W];

    dcache_array u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_i       (idx),
        .tag_o       (arr_tag),
        .valid_o     (arr_valid),
        .dirty_o     (arr_dirty),
        .line_o      (arr_line),
        .word_we_i   (word_we),
        .word_ofs_i  (ofs),
        .word_data_i (proc.proc_wdata),
        .line_we_i   (line_we),
        .line_tag_i  (tag),
        .line_data_i (mem.mem_rdata)
    );

    assign req = proc.proc_ren | proc.proc_wen;
    assign hit = arr_valid & (arr_tag == tag);

    assign proc.proc_stall = req & ~((state_q == IDLE) & hit);
    assign proc.proc_rdata = arr_line[ofs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory strobes depend on state_q only; a simultaneous read+write request is a read.
    always_comb begin
        state_d        = state_q;
        mem.mem_read   = 1'b0;
        mem.mem_write  = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        word_we        = 1'b0;
        line_we        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        word_we = proc.proc_wen & ~proc.proc_ren;
                    end else if (arr_valid & arr_dirty) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem.mem_write = 1'b1;
                mem.mem_addr  = {arr_tag, idx};
                mem.mem_wdata = arr_line;
                if (mem.mem_ready) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem.mem_read = 1'b1;
                mem.mem_addr = proc.proc_addr[ADDR_W-1:OFS_W];
                if (mem.mem_ready) begin
                    line_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Self-checking bench: a flat word-memory view of what the core must observe,
// a per-index residency model predicting hit/miss/write-back, and a line-level DRAM.
module tb_dcache_wb_dm;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_proc_if pif ();
    dcache_mem_if  mif ();

    dcache_wb_dm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .proc  (pif),
        .mem   (mif)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Architectural view: latest value of every word as the core wrote it.
    logic [31:0]  ref_mem [logic [29:0]];
    // Backing store contents per line address.
    logic [127:0] dram    [logic [27:0]];
    // Which line each index holds, and whether it has unwritten-back changes.
    bit           res_valid [8];
    logic [27:0]  res_line  [8];
    bit           res_dirty [8];

    logic [31:0]  obs_rdata;
    bit           obs_miss;
    bit           obs_wb;
    logic [27:0]  obs_wb_addr;
    logic [127:0] obs_wb_data;
    logic [27:0]  obs_fill_addr;
    int           obs_rd_cycles;

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [127:0] dram_line(input logic [27:0] l);
        line_t v;
        if (dram.exists(l)) return dram[l];
        for (int w = 0; w < 4; w++) v[2'(w)] = init_word({l, 2'(w)});
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [29:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [127:0] ref_line(input logic [27:0] l);
        line_t v;
        for (int w = 0; w < 4; w++) v[2'(w)] = ref_word({l, 2'(w)});
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Dirty data still in the cache is lost on reset: the core then sees DRAM again.
    task automatic model_reset();
        line_t v;
        for (int i = 0; i < 8; i++) begin
            if (res_valid[i] && res_dirty[i]) begin
                v = dram_line(res_line[i]);
                for (int w = 0; w < 4; w++) ref_mem[{res_line[i], 2'(w)}] = v[2'(w)];
            end
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
            res_line[i]  = '0;
        end
    endtask

    task automatic idle_cycle();
        pif.proc_ren = 1'b0;
        pif.proc_wen = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            mif.mem_ready = 1'b1;
            mif.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        chk("idle_stall", pif.proc_stall, 0);
        chk("idle_rd", mif.mem_read, 0);
        chk("idle_wr", mif.mem_write, 0);
        next_cycle();
        mif.mem_ready = 1'b0;
    endtask

    // One core request, from presentation to completion; wbd/ald < 0 pick random ready delays.
    task automatic do_req(input bit ren, input bit wen, input logic [29:0] addr,
                          input logic [31:0] wd, input int wbd, input int ald);
        logic [2:0]  idx;
        logic [27:0] line;
        logic [27:0] victim;
        bit          hit;
        int          d;
        idx  = addr[4:2];
        line = addr[29:2];
        pif.proc_ren   = ren;
        pif.proc_wen   = wen;
        pif.proc_addr  = addr;
        pif.proc_wdata = wd;
        obs_miss = 1'b0;
        obs_wb   = 1'b0;
        obs_rd_cycles = 0;
        hit = res_valid[idx] && (res_line[idx] == line);
        if (!hit) begin
            obs_miss = 1'b1;
            @(negedge clk);
            chk("miss_stall", pif.proc_stall, 1);
            chk("miss_first_rd", mif.mem_read, 0);
            chk("miss_first_wr", mif.mem_write, 0);
            next_cycle();
            if (res_valid[idx] && res_dirty[idx]) begin
                victim = res_line[idx];
                obs_wb = 1'b1;
                d = (wbd < 0) ? int'($urandom_range(0, 3)) : wbd;
                for (int c = 0; c <= d; c++) begin
                    if (c == d) mif.mem_ready = 1'b1;
                    @(negedge clk);
                    chk("wb_stall", pif.proc_stall, 1);
                    chk("wb_write", mif.mem_write, 1);
                    chk("wb_read", mif.mem_read, 0);
                    chk("wb_addr", mif.mem_addr, victim);
                    chk("wb_data", mif.mem_wdata, ref_line(victim));
                    obs_wb_addr = mif.mem_addr;
                    obs_wb_data = mif.mem_wdata;
                    next_cycle();
                    mif.mem_ready = 1'b0;
                end
                dram[victim] = obs_wb_data;
            end
            d = (ald < 0) ? int'($urandom_range(0, 5)) : ald;
            for (int c = 0; c <= d; c++) begin
                if (c == d) begin
                    mif.mem_ready = 1'b1;
                    mif.mem_rdata = dram_line(line);
                end
                @(negedge clk);
                chk("al_stall", pif.proc_stall, 1);
                chk("al_read", mif.mem_read, 1);
                chk("al_write", mif.mem_write, 0);
                chk("al_addr", mif.mem_addr, line);
                obs_fill_addr = mif.mem_addr;
                if (mif.mem_read === 1'b1) obs_rd_cycles++;
                next_cycle();
                mif.mem_ready = 1'b0;
                mif.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
            res_valid[idx] = 1'b1;
            res_line[idx]  = line;
            res_dirty[idx] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) begin
            mif.mem_ready = 1'b1;
            mif.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        chk("hit_stall", pif.proc_stall, 0);
        chk("hit_rd", mif.mem_read, 0);
        chk("hit_wr", mif.mem_write, 0);
        obs_rdata = pif.proc_rdata;
        if (ren) begin
            chk("hit_rdata", pif.proc_rdata, ref_word(addr));
        end else if (wen) begin
            ref_mem[addr]  = wd;
            res_dirty[idx] = 1'b1;
        end
        next_cycle();
        mif.mem_ready = 1'b0;
    endtask

    task automatic rand_req();
        logic [29:0] a;
        int unsigned k;
        a = {23'(0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
        k = $urandom_range(0, 9);
        if ($urandom_range(0, 7) == 0) idle_cycle();
        if (k == 0)      do_req(1'b1, 1'b1, a, $urandom, -1, -1);
        else if (k < 5)  do_req(1'b0, 1'b1, a, $urandom, -1, -1);
        else             do_req(1'b1, 1'b0, a, 32'h0, -1, -1);
    endtask

    initial begin
        pif.proc_ren   = 1'b0;
        pif.proc_wen   = 1'b0;
        pif.proc_addr  = '0;
        pif.proc_wdata = '0;
        mif.mem_ready  = 1'b0;
        mif.mem_rdata  = '0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", pif.proc_stall, 0);
        chk("rst_rd", mif.mem_read, 0);
        chk("rst_wr", mif.mem_write, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_wdata", mif.mem_wdata, 0);
        rst_n = 1'b1;
        next_cycle();

        dram[28'h4]    = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        ref_mem[30'h10] = 32'hAAAAAAAA;
        ref_mem[30'h11] = 32'hBBBBBBBB;
        ref_mem[30'h12] = 32'hCCCCCCCC;
        ref_mem[30'h13] = 32'hDDDDDDDD;

        // Reset asserted while a fill is outstanding.
        pif.proc_ren  = 1'b1;
        pif.proc_addr = 30'h10;
        @(negedge clk);
        chk("t6_stall", pif.proc_stall, 1);
        next_cycle();
        @(negedge clk);
        chk("t6_alloc_rd", mif.mem_read, 1);
        chk("t6_alloc_addr", mif.mem_addr, 28'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_rd", mif.mem_read, 0);
        chk("t6_async_wr", mif.mem_write, 0);
        pif.proc_ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        model_reset();

        do_req(1'b1, 1'b0, 30'h10, 32'h0, -1, 2);
        chk("t1_miss", obs_miss, 1);
        chk("t1_no_wb", obs_wb, 0);
        chk("t1_fill_addr", obs_fill_addr, 28'h4);
        chk("t1_rdata0", obs_rdata, 32'hAAAAAAAA);
        do_req(1'b1, 1'b0, 30'h11, 32'h0, -1, -1);
        chk("t1_hit", obs_miss, 0);
        chk("t1_rdata1", obs_rdata, 32'hBBBBBBBB);

        do_req(1'b0, 1'b1, 30'h12, 32'h12345678, -1, -1);
        chk("t2_write_hit", obs_miss, 0);
        do_req(1'b1, 1'b0, 30'h12, 32'h0, -1, -1);
        chk("t2_read_hit", obs_miss, 0);
        chk("t2_rdata", obs_rdata, 32'h12345678);

        do_req(1'b1, 1'b0, 30'h30, 32'h0, 1, 1);
        chk("t3_wb", obs_wb, 1);
        chk("t3_wb_addr", obs_wb_addr, 28'h4);
        chk("t3_wb_word2", obs_wb_data[95:64], 32'h12345678);
        chk("t3_fill_addr", obs_fill_addr, 28'hC);

        do_req(1'b1, 1'b0, 30'h10, 32'h0, -1, -1);
        chk("t4a_no_wb", obs_wb, 0);
        chk("t4a_rdata", obs_rdata, 32'hAAAAAAAA);
        do_req(1'b1, 1'b0, 30'h30, 32'h0, -1, -1);
        chk("t4b_miss", obs_miss, 1);
        chk("t4b_no_wb", obs_wb, 0);
        chk("t4b_fill_addr", obs_fill_addr, 28'hC);

        do_req(1'b1, 1'b0, 30'h54, 32'h0, -1, 4);
        chk("t5_rd_cycles", obs_rd_cycles, 5);

        // Write hit then write miss to the same index back to back.
        do_req(1'b0, 1'b1, 30'h55, 32'hCAFEF00D, -1, -1);
        do_req(1'b0, 1'b1, 30'h74, 32'h0BADBEEF, -1, -1);
        chk("bb_wb", obs_wb, 1);
        chk("bb_wb_word1", obs_wb_data[63:32], 32'hCAFEF00D);
        do_req(1'b1, 1'b1, 30'h74, 32'hFFFFFFFF, -1, -1);
        chk("both_as_read", obs_rdata, 32'h0BADBEEF);

        for (int i = 0; i < 250; i++) rand_req();

        pif.proc_ren = 1'b0;
        pif.proc_wen = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_stall", pif.proc_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        model_reset();

        for (int i = 0; i < 150; i++) rand_req();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
